// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port block-RAM arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant select between the instruction and data ports.
// ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise the data port always wins.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_req_i,
    input  logic  i_req_d,
    input  logic  i_load,
    output logic  o_valid,
    output port_e o_port
);

    logic  w_valid;
    port_e w_port;

    assign w_valid = i_req_i | i_req_d;

`ifdef ARB_ROUND_ROBIN_EN
    port_e r_last;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_port = PORT_I;
        if (i_req_i && i_req_d) begin
            w_port = (r_last == PORT_I) ? PORT_D : PORT_I;
        end else if (i_req_d) begin
            w_port = PORT_D;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_I;
        end else if (i_load && w_valid) begin
            r_last <= w_port;
        end
    end
`else
    logic w_unused;

    always_comb begin
        w_port = i_req_d ? PORT_D : PORT_I;
    end

    // Fixed priority keeps no history, so the clock and load strobe go unused here.
    assign w_unused = &{1'b0, clk, rst_n, i_load};
`endif

    assign o_valid = w_valid;
    assign o_port  = w_port;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch reads and data-port reads/writes onto one single-port RAM.
// Contention policy is set by ARB_ROUND_ROBIN_EN (see mem_arb_grant).
module mem_port_arbiter #(
    parameter int ADDR_W   = mem_arb_pkg::ADDR_W,
    parameter int DATA_W   = mem_arb_pkg::DATA_W,
    parameter int PROT_TOP = 0
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta
);

    import mem_arb_pkg::*;

    state_e            r_state;
    state_e            w_state_next;
    port_e             r_port;
    logic              r_blocked;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_d_err;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_grant_valid;
    port_e             w_grant_port;
    logic              w_prot_hit;
    logic              w_grant_d;

    mem_arb_grant u_grant (
        .clk     (clka),
        .rst_n   (rst_n),
        .i_req_i (i_req),
        .i_req_d (d_req),
        .i_load  (r_state == IDLE),
        .o_valid (w_grant_valid),
        .o_port  (w_grant_port)
    );

    assign w_prot_hit = (int'(d_addr) < PROT_TOP);
    assign w_grant_d  = (w_grant_port == PORT_D);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Async reset also clears mem_wea immediately, so no write lands after reset asserts.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_port    <= PORT_I;
            r_blocked <= 1'b0;
            r_wea     <= 1'b0;
            r_addra   <= '0;
            r_dina    <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_d_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_port    <= w_grant_port;
                        r_addra   <= w_grant_d ? d_addr : i_addr;
                        r_dina    <= d_wdata;
                        r_wea     <= w_grant_d && d_we && !w_prot_hit;
                        r_blocked <= w_grant_d && d_we && w_prot_hit;
                    end
                end
                ACCESS: begin
                    r_wea <= 1'b0;
                end
                RESP: begin
                    if (r_port == PORT_D) begin
                        r_d_rdata <= mem_douta;
                        r_d_ack   <= 1'b1;
                        r_d_err   <= r_blocked;
                    end else begin
                        r_i_rdata <= mem_douta;
                        r_i_ack   <= 1'b1;
                    end
                end
                default: begin
                    r_wea <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;
    assign mem_wea   = r_wea;
    assign mem_addra = r_addra;
    assign mem_dina  = r_dina;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port access arbiter placed directly upstream of the 16-bit x 1024-word single-port block RAM (mem16x10_block). It accepts word requests from the instruction-fetch port (read-only) and the data port (read/write) and serialises them onto the RAM's single port. It drives the RAM's wea/addra/dina from registers, captures douta and returns it with a one-cycle ack pulse. Writes below a protected boundary are blocked.

## Interface
- ADDR_W, 10, word address width; matches RAM depth 1024
- DATA_W, 16, data width; matches RAM word
- PROT_TOP, 0, data-port writes to addresses < PROT_TOP are blocked; 0 = no protection
- clka  in  1  clock, shared with the RAM
- rst_n  in  1  reset; asynchronous, active-low
- i_req  in  1  instruction-port read request; held until i_ack
- i_addr  in  ADDR_W  instruction-port word address
- i_ack  out  1  one-cycle pulse; i_rdata valid
- i_rdata  out  DATA_W  instruction read data, held until next i_ack
- d_req  in  1  data-port request; held until d_ack
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data-port word address
- d_wdata  in  DATA_W  write data
- d_ack  out  1  one-cycle pulse; d_rdata/d_err valid
- d_rdata  out  DATA_W  read data, or RAM write-first data on writes
- d_err  out  1  high with d_ack when the write was blocked
- mem_wea  out  1  to RAM wea
- mem_addra  out  ADDR_W  to RAM addra
- mem_dina  out  DATA_W  to RAM dina
- mem_douta  in  DATA_W  from RAM douta; valid one edge after address sampled

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req at edge, grant one port, load mem_addra/mem_dina/mem_wea, record granted port, go ACCESS. No req: stay IDLE, mem_wea = 0.
- ACCESS: the RAM samples its inputs at this edge. mem_wea cleared, go RESP.
- RESP: at edge capture mem_douta into the granted port's rdata, pulse its ack, go IDLE.
- Blocked write (d_we=1, d_addr < PROT_TOP): mem_wea stays 0 (read performed instead), d_err=1 with d_ack, d_rdata = old contents.
- Requester must drop req (or present a new transaction) in the ack cycle. A req still high at the IDLE edge after ack is taken as a new transaction.
- Both req in IDLE: arbitration per Configuration.
- Reset values: all acks, d_err, mem_wea = 0; rdata, mem_addra, mem_dina = 0; last-grant = I.
- Reset mid-transaction: transaction dropped, no ack. mem_wea drops asynchronously, so no partial write occurs after reset asserts.

## Timing
- Edge E0: req sampled in IDLE; mem_* registered.
- E1: RAM access.
- E2: rdata captured; ack high for the cycle after E2.
- Latency: 3 edges from req to ack. Throughput: 1 access per 3 cycles.
- Back-to-back requests from the losing port are served starting at E3.
- Address and data are not re-sampled after E0, so changes during ACCESS/RESP are ignored.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted last; last-grant updates on every grant.
- Undefined: fixed priority, data port always wins; the instruction port can starve under continuous d_req.

## Structure
- Package mem_arb_pkg: ADDR_W/DATA_W constants, FSM state enum (IDLE, ACCESS, RESP), port-select enum (PORT_I, PORT_D).
- One sub-module, mem_arb_grant: combinational grant select plus last-grant register (round-robin variant under the macro).
- RAM instantiated by the parent, not inside this block.

## Test plan
- Single I read, addr 23 (RAM preloaded word n = n) -> i_ack 3 edges after req, i_rdata = 23; d_ack stays 0.
- D write 166 to addr 332, then D read 332 -> first d_ack with d_rdata = 166, d_err = 0; second read returns 166.
- PROT_TOP=64, D write 0xFFFF to addr 63 -> d_err = 1, mem_wea never high, a later read of 63 returns 63.
- Both req continuously, I addr 1, D addr 2: with ARB_ROUND_ROBIN_EN, acks alternate D, I, D, I. Without it, only d_ack occurs.
- Write to addr 1023, assert rst_n low during ACCESS -> no ack, outputs 0, FSM IDLE; after release, a read of 1023 is served normally.
- D read addr 1020 with req held through ack -> second transaction starts at E3, second d_ack 3 edges later, value 1020.
